// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared types, constants and range helper for the clock activity monitor.
package clk_mon_pkg;
    localparam int DEF_CNT_W = 16;
    typedef logic [DEF_CNT_W-1:0] cnt_t;
    // Counters saturate at the low CNT_W bits of this value (CNT_W <= 32).
    localparam logic [31:0] CNT_MAX = '1;

    function automatic logic in_range(input logic [31:0] cnt, input logic [31:0] lo, input logic [31:0] hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction
endpackage

// File: rtl/clk_mon_chan.sv
// clk_mon_chan: one monitored clock -- synchroniser, edge detect, saturating
// edge counter, lock hysteresis and registered ok/stuck/count.
module clk_mon_chan
    import clk_mon_pkg::*;
#(
    parameter int  SYNC_STAGES  = 2,
    parameter int  GOOD_WINDOWS = 3,
    parameter type cnt_t        = clk_mon_pkg::cnt_t
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic enable,
    input  logic win_close,
    input  logic tick_in,
    input  cnt_t min_cnt,
    input  cnt_t max_cnt,
    output cnt_t count_out,
    output logic ok,
    output logic stuck
);
    localparam int   GR_W = $clog2(GOOD_WINDOWS + 1);
    localparam cnt_t SAT  = cnt_t'(CNT_MAX);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_edge;
    cnt_t                   r_cnt;
    logic [GR_W-1:0]        r_good_run;
    cnt_t                   w_cnt_next;
    logic                   w_in;
    logic [GR_W-1:0]        w_gr_next;

    // Next count includes an edge pulse landing in the closing cycle.
    assign w_cnt_next = (r_edge && r_cnt != SAT) ? r_cnt + 1'b1 : r_cnt;
    assign w_in       = in_range(32'(w_cnt_next), 32'(min_cnt), 32'(max_cnt));
    assign w_gr_next  = (r_good_run == GR_W'(GOOD_WINDOWS)) ? r_good_run : r_good_run + 1'b1;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_sync     <= '0;
            r_prev     <= 1'b0;
            r_edge     <= 1'b0;
            r_cnt      <= '0;
            r_good_run <= '0;
            count_out  <= '0;
            ok         <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_edge <= r_sync[SYNC_STAGES-1] & ~r_prev;
            if (!enable) begin
                r_cnt      <= '0;
                r_good_run <= '0;
                ok         <= 1'b0;
            end else if (win_close) begin
                r_cnt      <= '0;
                count_out  <= w_cnt_next;
                stuck      <= (w_cnt_next == '0);
                r_good_run <= w_in ? w_gr_next : '0;
                ok         <= w_in && (w_gr_next == GR_W'(GOOD_WINDOWS));
            end else begin
                r_cnt <= w_cnt_next;
            end
        end
    end
endmodule

// File: rtl/clk_activity_mon.sv
// clk_activity_mon: multi-channel clock activity/frequency monitor; owns the
// measurement window and packs per-channel results.
module clk_activity_mon
    import clk_mon_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int WINDOW       = 1024,
    parameter int CNT_W        = 16,
    parameter int GOOD_WINDOWS = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [CHANNELS-1:0]       tick_in,
    input  logic [CHANNELS*CNT_W-1:0] min_cnt,
    input  logic [CHANNELS*CNT_W-1:0] max_cnt,
    output logic [CHANNELS*CNT_W-1:0] count_out,
    output logic                      count_valid,
    output logic [CHANNELS-1:0]       ok,
    output logic [CHANNELS-1:0]       stuck,
    output logic                      all_ok
);
    localparam int WCW = $clog2(WINDOW);

    logic [WCW-1:0] r_wcnt;
    logic           w_close;

    assign w_close = enable && (r_wcnt == WCW'(WINDOW - 1));
    assign all_ok  = &ok;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_wcnt      <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= w_close;
            r_wcnt      <= (!enable || w_close) ? '0 : r_wcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clk_mon_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .GOOD_WINDOWS(GOOD_WINDOWS),
            .cnt_t       (logic [CNT_W-1:0])
        ) u_chan (
            .clk_sys  (clk_sys),
            .reset_n  (reset_n),
            .enable   (enable),
            .win_close(w_close),
            .tick_in  (tick_in[i]),
            .min_cnt  (min_cnt[i*CNT_W +: CNT_W]),
            .max_cnt  (max_cnt[i*CNT_W +: CNT_W]),
            .count_out(count_out[i*CNT_W +: CNT_W]),
            .ok       (ok[i]),
            .stuck    (stuck[i])
        );
    end
endmodule

// File: tb/tb_clk_activity_mon.sv
// tb_clk_activity_mon: directed checks of lock, stuck, loss of lock,
// saturation, enable and mid-window reset behaviour.
module tb_clk_activity_mon;
    localparam int CH = 4;
    localparam int W  = 64;
    localparam int CW = 16;
    localparam int SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n, enable;
    logic [CH-1:0]     tick, tick_s;
    logic [CH*CW-1:0]  min_c, max_c, cnt;
    logic [CH*SW-1:0]  min_s, max_s, cnt_s;
    logic              cv, cv_s, all_ok, all_ok_s;
    logic [CH-1:0]     ok, stuck, ok_s, stuck_s;

    int half[CH], ph[CH], half_s[CH], ph_s[CH];
    int vectors = 0;
    int miscompares = 0;
    int n, cvs;

    clk_activity_mon #(.CHANNELS(CH), .WINDOW(W), .CNT_W(CW)) dut (
        .clk_sys(clk), .reset_n(reset_n), .enable(enable), .tick_in(tick),
        .min_cnt(min_c), .max_cnt(max_c), .count_out(cnt), .count_valid(cv),
        .ok(ok), .stuck(stuck), .all_ok(all_ok)
    );

    clk_activity_mon #(.CHANNELS(CH), .WINDOW(W), .CNT_W(SW)) dut_sat (
        .clk_sys(clk), .reset_n(reset_n), .enable(enable), .tick_in(tick_s),
        .min_cnt(min_s), .max_cnt(max_s), .count_out(cnt_s), .count_valid(cv_s),
        .ok(ok_s), .stuck(stuck_s), .all_ok(all_ok_s)
    );

    // Advance to the next falling edge, then move each toggle generator on.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < CH; i++) begin
            if (half[i] != 0) begin
                ph[i]++;
                if (ph[i] >= half[i]) begin tick[i] = ~tick[i]; ph[i] = 0; end
            end
            if (half_s[i] != 0) begin
                ph_s[i]++;
                if (ph_s[i] >= half_s[i]) begin tick_s[i] = ~tick_s[i]; ph_s[i] = 0; end
            end
        end
    endtask

    task automatic steps(input int k);
        repeat (k) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Edges from now until count_valid is seen; 200 means it never came.
    task automatic wait_cv(output int k);
        k = 0;
        do begin step(); k++; end while (!cv && k < 200);
    endtask

    function automatic logic [31:0] c(input int i);
        return 32'(cnt[i*CW +: CW]);
    endfunction

    function automatic logic [31:0] cs(input int i);
        return 32'(cnt_s[i*SW +: SW]);
    endfunction

    initial begin
        reset_n = 1'b0; enable = 1'b0; tick = '0; tick_s = '0;
        for (int i = 0; i < CH; i++) begin
            half[i] = 0; ph[i] = 0; half_s[i] = 0; ph_s[i] = 0;
            min_s[i*SW +: SW] = 4'd0;
            max_s[i*SW +: SW] = 4'd14;
        end
        min_c[0*CW +: CW] = 16'd14; max_c[0*CW +: CW] = 16'd18;
        min_c[1*CW +: CW] = 16'd1;  max_c[1*CW +: CW] = 16'd100;
        min_c[2*CW +: CW] = 16'd7;  max_c[2*CW +: CW] = 16'd9;
        min_c[3*CW +: CW] = 16'd20; max_c[3*CW +: CW] = 16'd10;
        steps(3);
        chk("rst_count_out", cnt, 0);
        chk("rst_count_valid", 32'(cv), 0);
        chk("rst_ok", 32'(ok), 0);
        chk("rst_stuck", 32'(stuck), 0);
        chk("rst_all_ok", 32'(all_ok), 0);
        chk("rst_sat_count_out", 32'(cnt_s), 0);

        // Lock: ch0 period 4, ch1 tied low, ch2 period 8, ch3 period 4 with min>max
        reset_n = 1'b1; enable = 1'b1;
        half[0] = 2; half[2] = 4; half[3] = 2; half_s[0] = 1; half_s[1] = 4;
        wait_cv(n);
        chk("w1_first_cv", n, W);
        chk("w1_c0_15or16", 32'((c(0) == 15) || (c(0) == 16)), 1);
        chk("w1_ok0", 32'(ok[0]), 0);
        chk("w1_stuck0", 32'(stuck[0]), 0);
        chk("w1_stuck1", 32'(stuck[1]), 1);
        chk("w1_ok1", 32'(ok[1]), 0);
        chk("w1_c1", c(1), 0);
        chk("w1_all_ok", 32'(all_ok), 0);
        wait_cv(n);
        chk("w2_period", n, W);
        chk("w2_ok0", 32'(ok[0]), 0);
        wait_cv(n);
        chk("w3_period", n, W);
        chk("w3_ok0", 32'(ok[0]), 1);
        chk("w3_c0", c(0), 16);
        chk("w3_c2", c(2), 8);
        chk("w3_ok2", 32'(ok[2]), 1);
        chk("w3_c3", c(3), 16);
        chk("w3_ok3_min_gt_max", 32'(ok[3]), 0);
        chk("w3_stuck3", 32'(stuck[3]), 0);
        chk("w3_all_ok", 32'(all_ok), 0);
        chk("sat_c0", cs(0), 15);
        chk("sat_ok0", 32'(ok_s[0]), 0);
        chk("sat_c1", cs(1), 8);
        chk("sat_ok1", 32'(ok_s[1]), 1);
        chk("sat_stuck2", 32'(stuck_s[2]), 1);
        chk("sat_ok2_zero_in_range", 32'(ok_s[2]), 1);

        // Loss of lock: one fast window on ch0
        half[0] = 1;
        wait_cv(n);
        chk("w4_period", n, W);
        chk("w4_c0_fast", 32'(c(0) >= 28), 1);
        chk("w4_ok0_drop", 32'(ok[0]), 0);
        half[0] = 2;
        wait_cv(n);
        chk("w5_ok0", 32'(ok[0]), 0);
        wait_cv(n);
        chk("w6_ok0", 32'(ok[0]), 0);
        wait_cv(n);
        chk("w7_ok0_relock", 32'(ok[0]), 1);

        // Enable dropped at wcnt=30
        steps(30);
        enable = 1'b0;
        cvs = 0;
        repeat (100) begin step(); cvs += int'(cv); end
        chk("dis_no_cv", cvs, 0);
        chk("dis_ok", 32'(ok), 0);
        chk("dis_c0_hold", c(0), 16);
        chk("dis_stuck1_hold", 32'(stuck[1]), 1);
        enable = 1'b1;
        wait_cv(n);
        chk("reen_first_cv", n, W);
        wait_cv(n);
        wait_cv(n);
        chk("reen_ok0_lock", 32'(ok[0]), 1);

        // Reset pulse at wcnt=40 while locked
        steps(40);
        reset_n = 1'b0;
        step();
        chk("mrst_count_out", cnt, 0);
        chk("mrst_ok", 32'(ok), 0);
        chk("mrst_stuck", 32'(stuck), 0);
        chk("mrst_cv", 32'(cv), 0);
        chk("mrst_all_ok", 32'(all_ok), 0);
        reset_n = 1'b1;
        half[1] = 2;
        min_c[3*CW +: CW] = 16'd14; max_c[3*CW +: CW] = 16'd18;
        wait_cv(n);
        chk("mrst_first_cv", n, W);
        wait_cv(n);
        chk("mrst_all_ok_w2", 32'(all_ok), 0);
        wait_cv(n);
        chk("mrst_ok1_w3", 32'(ok[1]), 1);
        chk("mrst_all_ok_w3", 32'(all_ok), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
